fb_block_writer: RTL and testbench
==================================

// Module: fb_block_writer
// PURPOSE
//  Producer side of the display frame buffer: accepts 128-bit AES blocks from the SIMD pipeline over a
//  valid/ready handshake and serializes them into byte writes to the dual-port pixel RAM.
//  The VGA path reads that RAM, so the writer must place bytes in the same bank layout:
//  bank 0 at base 0, bank 1 at base BANK_OFFSET. Signals frame completion to the control FSM.
// PARAMETERS
//  FRAME_BYTES  10000  bytes per frame (100x100 image); write count that ends a frame
//  BANK_OFFSET  10001  base address of bank 1 (bank 0 base = 0)
//  ADDR_W       16     RAM address width
// PORTS
//  clk          in   1       system clock (same domain as the RAM write port)
//  rst          in   1       synchronous reset, active-low
//  frame_start  in   1       pulse: begin new frame; latches bank_sel; aborts any frame in progress
//  bank_sel     in   1       0 = plaintext bank, 1 = ciphertext bank; sampled only on frame_start
//  stall        in   1       1 = suspend RAM writes this cycle (state and counters frozen)
//  in_valid     in   1       in_block valid
//  in_ready     out  1       block accepted when in_valid & in_ready
//  in_block     in   128     AES block; byte 0 = in_block[127:120], byte 15 = in_block[7:0]
//  wr_en        out  1       RAM write strobe
//  wr_addr      out  ADDR_W  RAM byte address = base + byte_count
//  wr_data      out  8       RAM write data
//  busy         out  1       frame in progress (state != IDLE)
//  frame_done   out  1       one-cycle pulse after the final byte of the frame is written
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE; byte_count=0; byte_idx=0; bank=0;
//   in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0. Reset mid-frame discards everything.
//  States: IDLE -> LOAD on frame_start; LOAD -> WRITE on accept; WRITE -> LOAD after byte 15
//   with no new block; WRITE -> WRITE (byte_idx=0) after byte 15 when a new block is accepted same cycle;
//   WRITE/LOAD -> DONE when byte_count reaches FRAME_BYTES; DONE -> IDLE next cycle (frame_done=1 in DONE).
//  frame_start in any state: byte_count=0, byte_idx=0, bank latched, next state LOAD; outranks all else.
//  in_ready = (state==LOAD) | (state==WRITE & byte_idx==15 & !stall & last write not frame-final).
//   Gives sustained throughput of 1 byte/cycle (16 cycles/block, no bubble). Never high in IDLE/DONE.
//  Accepted block stored in a 128-bit holding register; bytes emitted MSB-first, one per cycle.
//  Outputs are registered: wr_en/wr_addr/wr_data valid the cycle after the byte is selected.
//   Latency: accept at edge N -> first wr_en at edge N+1 visible, byte 15 at N+16.
//  wr_addr = (bank ? BANK_OFFSET : 0) + byte_count, computed ADDR_W wide; no wrap (max 20000 < 2^16).
//  stall=1: wr_en=0 next cycle, byte_idx/byte_count/state unchanged, in_ready=0; resumes with same byte.
//  Frame end: when byte_count+1 == FRAME_BYTES on a write, remaining bytes of that block are dropped,
//   in_ready stays 0, state -> DONE. FRAME_BYTES multiple of 16 (default) drops nothing.
//  in_valid held high without frame_start (IDLE) is ignored; no writes occur outside a frame.
//  busy = (state != IDLE); goes 0 the cycle after frame_done.
// STRUCTURE
//  Package fb_pkg: fb_state_t enum {IDLE, LOAD, WRITE, DONE}; localparams FB_FRAME_BYTES=10000,
//   FB_BANK_OFFSET=10001, FB_ADDR_W=16, AES_BLOCK_W=128; shared with the VGA offset logic.
//  One sub-module: fb_byte_serializer (holding register + byte_idx mux, load/advance/stall inputs);
//   FSM, counters and address generation stay in fb_block_writer.
// TESTING
//  1 Reset: hold rst=0 3 cycles with in_valid=1 -> all outputs 0, no wr_en; release, no frame_start -> still idle.
//  2 Single block: frame_start bank_sel=0, block 0x000102..0F -> 16 writes addr 0..15 data 0x00..0x0F, in order.
//  3 Bank 1 full frame, back-to-back 625 blocks, in_valid=1 always -> 10000 consecutive wr_en cycles,
//    addr 10001..20000, no bubbles, frame_done one cycle after addr 20000, busy falls next cycle.
//  4 Stall: assert stall on byte 5 for 3 cycles -> wr_en low 3 cycles, byte 5 then written, no skip/duplicate.
//  5 Abort: frame_start(bank 0) mid-block at byte_count=37 -> next write addr 0 from newly accepted block.
//  6 FRAME_BYTES=24 build: 2 blocks offered -> 24 writes, bytes 8..15 of block 2 dropped, frame_done pulsed.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and writer state encoding.
// Shared by the block writer and the VGA offset logic.
package fb_pkg;

    localparam int unsigned FB_FRAME_BYTES  = 10000;
    localparam int unsigned FB_BANK_OFFSET  = 10001;
    localparam int unsigned FB_ADDR_W       = 16;
    localparam int unsigned AES_BLOCK_W     = 128;
    localparam int unsigned AES_BLOCK_BYTES = AES_BLOCK_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } fb_state_t;

endpackage

// File: rtl/fb_byte_serializer.sv
// fb_byte_serializer: holds one AES block and walks it
// MSB-first, one byte per advance.
module fb_byte_serializer
    import fb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   advance,
    input  logic                   stall,
    input  logic [AES_BLOCK_W-1:0] block,
    output logic [7:0]             byte_out,
    output logic [3:0]             byte_idx,
    output logic                   last_byte
);

    localparam int MSB = AES_BLOCK_W - 1;

    logic [AES_BLOCK_W-1:0] hold;

    // Holding register and byte pointer; clear wins over load,
    // load wins over advance, stall freezes the pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (load) begin
            hold     <= block;
            byte_idx <= '0;
        end else if (advance && !stall) begin
            byte_idx <= byte_idx + 4'd1;
        end
    end

    // Byte 0 is the most significant byte of the block.
    always_comb begin
        byte_out  = hold[MSB - 8*int'(byte_idx) -: 8];
        last_byte = (byte_idx == 4'd15);
    end

endmodule

// File: rtl/fb_block_writer.sv
// fb_block_writer: serializes accepted AES blocks into byte
// writes of the banked pixel RAM and flags frame completion.
module fb_block_writer
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FB_FRAME_BYTES,
    parameter int unsigned BANK_OFFSET = FB_BANK_OFFSET,
    parameter int unsigned ADDR_W      = FB_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   bank_sel,
    input  logic                   stall,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [7:0]             wr_data,
    output logic                   busy,
    output logic                   frame_done
);

    fb_state_t         state;
    logic [ADDR_W-1:0] byte_count;
    logic [ADDR_W-1:0] base;
    logic              bank;

    logic [7:0]        cur_byte;
    logic [3:0]        byte_idx;
    logic              blk_last;

    logic              frame_last;
    logic              do_write;
    logic              advance;
    logic              accept;

    fb_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start),
        .load      (accept),
        .advance   (advance),
        .stall     (stall),
        .block     (in_block),
        .byte_out  (cur_byte),
        .byte_idx  (byte_idx),
        .last_byte (blk_last)
    );

    // Handshake and write qualification; a new block is taken
    // only while the final byte of the current one goes out,
    // unless that byte also closes the frame.
    always_comb begin
        base       = bank ? ADDR_W'(BANK_OFFSET) : '0;
        frame_last = (byte_count == ADDR_W'(FRAME_BYTES - 1));
        advance    = (state == WRITE) && !frame_start;
        do_write   = advance && !stall;
        in_ready   = !frame_start &&
                     ((state == LOAD) ||
                      ((state == WRITE) && blk_last &&
                       !stall && !frame_last));
        accept     = in_valid && in_ready;
    end

    // Frame FSM, byte counter and registered RAM write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            byte_count <= '0;
            bank       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                state      <= LOAD;
                byte_count <= '0;
                bank       <= bank_sel;
                busy       <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    LOAD: begin
                        if (accept) state <= WRITE;
                    end
                    WRITE: begin
                        if (do_write) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= base + byte_count;
                            wr_data    <= cur_byte;
                            byte_count <= byte_count + ADDR_W'(1);
                            if (frame_last)
                                state <= DONE;
                            else if (blk_last && !accept)
                                state <= LOAD;
                        end
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fb_block_writer.sv
// tb_fb_block_writer: scoreboard bench for the frame-buffer
// block writer, default build plus a 24-byte frame build.
module tb_fb_block_writer;
    import fb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         frame_start, bank_sel, stall, in_valid, in_ready;
    logic [127:0] in_block;
    logic         wr_en, busy, frame_done;
    logic [15:0]  wr_addr;
    logic [7:0]   wr_data;

    logic         s_frame_start, s_bank_sel, s_stall, s_in_valid, s_in_ready;
    logic [127:0] s_in_block;
    logic         s_wr_en, s_busy, s_frame_done;
    logic [15:0]  s_wr_addr;
    logic [7:0]   s_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] q[$];
    int unsigned exp_base, exp_cnt, exp_limit;

    fb_block_writer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .bank_sel(bank_sel), .stall(stall), .in_valid(in_valid),
        .in_ready(in_ready), .in_block(in_block), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done)
    );

    fb_block_writer #(.FRAME_BYTES(24)) dut24 (
        .clk(clk), .rst(rst), .frame_start(s_frame_start),
        .bank_sel(s_bank_sel), .stall(s_stall), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_block(s_in_block), .wr_en(s_wr_en),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy(s_busy),
        .frame_done(s_frame_done)
    );

    function automatic logic [127:0] rnd_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Model: an accepted block yields bytes MSB-first at base+count,
    // truncated at the frame length.
    task automatic push_block(input logic [127:0] blk);
        for (int k = 0; k < 16; k++) begin
            if (exp_cnt < exp_limit)
                q.push_back({16'(exp_base + exp_cnt), blk[127 - 8*k -: 8]});
            exp_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        s_in_valid = 1'b1;
        in_block = rnd_block();
        s_in_block = rnd_block();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({in_ready, wr_en, busy, frame_done, wr_addr, wr_data} !== 28'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i,
                         {in_ready, wr_en, busy, frame_done, wr_addr, wr_data});
            end
            n_checks++;
            if ({s_in_ready, s_wr_en, s_busy, s_frame_done, s_wr_addr, s_wr_data} !== 28'h0) begin
                n_fail++;
                $display("FAIL reset_outputs24 cycle %0d: got %h expected 0", i,
                         {s_in_ready, s_wr_en, s_busy, s_frame_done, s_wr_addr, s_wr_data});
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, wr_en, busy, frame_done} !== 4'b0) begin
                n_fail++;
                $display("FAIL idle_no_start cycle %0d: got %b expected 0000", i,
                         {in_ready, wr_en, busy, frame_done});
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s_in_valid = 1'b0;
    endtask

    task automatic test_single_block();
        int got, cyc;
        logic hs;
        logic [23:0] e;
        q.delete();
        exp_base = 0; exp_cnt = 0; exp_limit = 10000;
        frame_start = 1'b1; bank_sel = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        in_valid = 1'b1;
        in_block = 128'h000102030405060708090A0B0C0D0E0F;
        got = 0; cyc = 0;
        while (got < 16 && cyc < 64) begin
            @(negedge clk);
            if (wr_en) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_extra: got addr=%0d data=%h expected none", wr_addr, wr_data);
                end else begin
                    e = q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        n_fail++;
                        $display("FAIL single_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 wr_addr, wr_data, e[23:8], e[7:0]);
                    end
                end
                got++;
            end
            hs = in_valid && in_ready;
            if (hs) push_block(in_block);
            @(posedge clk); #1;
            if (hs) in_valid = 1'b0;
            cyc++;
        end
        n_checks++;
        if (got != 16) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes expected 16", got);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready, wr_en} !== 3'b110) begin
            n_fail++;
            $display("FAIL single_after: got busy/ready/wr_en=%b expected 110", {busy, in_ready, wr_en});
        end
    endtask

    task automatic test_full_frame_bank1();
        int got, cyc, bubbles, nblk;
        logic hs;
        logic [23:0] e;
        q.delete();
        exp_base = 10001; exp_cnt = 0; exp_limit = 10000;
        @(posedge clk); #1;
        frame_start = 1'b1; bank_sel = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0; bank_sel = 1'b0;
        in_valid = 1'b1; in_block = rnd_block();
        got = 0; cyc = 0; bubbles = 0; nblk = 0;
        while (got < 10000 && cyc < 12000) begin
            @(negedge clk);
            if (wr_en) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_extra: got addr=%0d expected none", wr_addr);
                end else begin
                    e = q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        n_fail++;
                        $display("FAIL frame_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 wr_addr, wr_data, e[23:8], e[7:0]);
                    end
                end
                got++;
            end else if (got > 0) begin
                bubbles++;
            end
            hs = in_valid && in_ready;
            if (hs) begin
                push_block(in_block);
                nblk++;
            end
            @(posedge clk); #1;
            if (hs) in_block = rnd_block();
            cyc++;
        end
        n_checks++;
        if (got != 10000) begin
            n_fail++;
            $display("FAIL frame_count: got %0d writes expected 10000", got);
        end
        n_checks++;
        if (bubbles != 0) begin
            n_fail++;
            $display("FAIL frame_bubbles: got %0d expected 0", bubbles);
        end
        n_checks++;
        if (nblk != 625 || q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_blocks: got %0d blocks, %0d left expected 625, 0", nblk, q.size());
        end
        @(negedge clk);
        n_checks++;
        if ({frame_done, busy, wr_en, in_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL frame_done_pulse: got done/busy/wr/rdy=%b expected 1100",
                     {frame_done, busy, wr_en, in_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({frame_done, busy, wr_en, in_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL frame_busy_fall: got done/busy/wr/rdy=%b expected 0000",
                     {frame_done, busy, wr_en, in_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({wr_en, in_ready, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_frame: got wr/rdy/busy=%b expected 000", {wr_en, in_ready, busy});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        int got, cyc, gaps, stall_cyc;
        logic hs, stall_done, rdy_bad;
        logic [23:0] e;
        q.delete();
        exp_base = 0; exp_cnt = 0; exp_limit = 10000;
        frame_start = 1'b1; bank_sel = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        in_valid = 1'b1; in_block = rnd_block();
        got = 0; cyc = 0; gaps = 0; stall_cyc = 0;
        stall_done = 1'b0; rdy_bad = 1'b0;
        while (got < 16 && cyc < 64) begin
            @(negedge clk);
            if (wr_en) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_extra: got addr=%0d expected none", wr_addr);
                end else begin
                    e = q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        n_fail++;
                        $display("FAIL stall_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 wr_addr, wr_data, e[23:8], e[7:0]);
                    end
                end
                got++;
            end else if (got == 5) begin
                gaps++;
                if (in_ready) rdy_bad = 1'b1;
            end
            hs = in_valid && in_ready;
            if (hs) push_block(in_block);
            @(posedge clk); #1;
            if (hs) in_valid = 1'b0;
            if (stall_cyc > 0) begin
                stall_cyc--;
                if (stall_cyc == 0) stall = 1'b0;
            end else if (got == 4 && !stall_done) begin
                stall = 1'b1;
                stall_cyc = 3;
                stall_done = 1'b1;
            end
            cyc++;
        end
        stall = 1'b0;
        n_checks++;
        if (got != 16 || gaps != 3) begin
            n_fail++;
            $display("FAIL stall_gaps: got %0d writes, %0d gaps expected 16, 3", got, gaps);
        end
        n_checks++;
        if (rdy_bad) begin
            n_fail++;
            $display("FAIL stall_ready: got in_ready=1 during stall expected 0");
        end
    endtask

    task automatic test_abort();
        int got, cyc, old_w, new_w;
        logic hs, aborted;
        logic [23:0] e;
        q.delete();
        exp_base = 10001; exp_cnt = 0; exp_limit = 10000;
        frame_start = 1'b1; bank_sel = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        in_valid = 1'b1; in_block = rnd_block();
        got = 0; cyc = 0; old_w = 0; new_w = 0; aborted = 1'b0;
        while (new_w < 16 && cyc < 400) begin
            @(negedge clk);
            if (wr_en) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL abort_extra: got addr=%0d expected none", wr_addr);
                end else begin
                    e = q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        n_fail++;
                        $display("FAIL abort_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 wr_addr, wr_data, e[23:8], e[7:0]);
                    end
                end
                if (wr_addr >= 16'd10001) old_w++;
                else new_w++;
                got++;
            end
            hs = in_valid && in_ready;
            if (hs) push_block(in_block);
            @(posedge clk); #1;
            if (frame_start) frame_start = 1'b0;
            if (hs && aborted) begin
                in_valid = 1'b0;
            end else if (hs) begin
                in_block = rnd_block();
            end
            if (!aborted && got == 36) begin
                frame_start = 1'b1;
                bank_sel = 1'b0;
                while (q.size() > 1) void'(q.pop_back());
                exp_base = 0; exp_cnt = 0;
                in_block = rnd_block();
                in_valid = 1'b1;
                aborted = 1'b1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (old_w != 37 || new_w != 16) begin
            n_fail++;
            $display("FAIL abort_counts: got old=%0d new=%0d expected 37, 16", old_w, new_w);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_leftover: got %0d pending expected 0", q.size());
        end
    endtask

    task automatic test_short_frame();
        int got, cyc, nblk, last_w, done_at, done_cnt;
        logic hs;
        logic [23:0] e;
        q.delete();
        exp_base = 0; exp_cnt = 0; exp_limit = 24;
        s_frame_start = 1'b1; s_bank_sel = 1'b0;
        @(posedge clk); #1;
        s_frame_start = 1'b0;
        s_in_valid = 1'b1; s_in_block = rnd_block();
        got = 0; cyc = 0; nblk = 0;
        last_w = -1; done_at = -1; done_cnt = 0;
        while (cyc < 60) begin
            @(negedge clk);
            if (s_wr_en) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL short_extra: got addr=%0d expected none", s_wr_addr);
                end else begin
                    e = q.pop_front();
                    if ({s_wr_addr, s_wr_data} !== e) begin
                        n_fail++;
                        $display("FAIL short_write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 s_wr_addr, s_wr_data, e[23:8], e[7:0]);
                    end
                end
                got++;
                last_w = cyc;
            end
            if (s_frame_done) begin
                done_cnt++;
                done_at = cyc;
            end
            hs = s_in_valid && s_in_ready;
            if (hs) begin
                push_block(s_in_block);
                nblk++;
            end
            @(posedge clk); #1;
            if (hs) s_in_block = rnd_block();
            cyc++;
        end
        n_checks++;
        if (got != 24 || nblk != 2) begin
            n_fail++;
            $display("FAIL short_counts: got %0d writes, %0d blocks expected 24, 2", got, nblk);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != last_w + 1) begin
            n_fail++;
            $display("FAIL short_done: got %0d pulses at %0d expected 1 at %0d",
                     done_cnt, done_at, last_w + 1);
        end
        n_checks++;
        if ({s_busy, s_in_ready, s_wr_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL short_idle: got busy/rdy/wr=%b expected 000", {s_busy, s_in_ready, s_wr_en});
        end
        s_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        frame_start = 1'b0; bank_sel = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_block = '0;
        s_frame_start = 1'b0; s_bank_sel = 1'b0; s_stall = 1'b0;
        s_in_valid = 1'b0; s_in_block = '0;
        test_reset();
        test_single_block();
        test_full_frame_bank1();
        test_stall();
        test_abort();
        test_short_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
